// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB: accept, drive one TLB port for one cycle, respond.
// Latency: TLB port active one cycle after accept, done pulse the cycle after; one op every 3 cycles.
// Backpressure: op_ready is high only in IDLE; op_valid while busy is ignored and must be held.
package csr_tlbDefines;
    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } PhytranItem;
endpackage

module tlb_op_ctrl
    import csr_tlbDefines::*;
#(
    parameter int TLBNUM     = 16,
    parameter int TLBNUMSIZE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [2:0]            op_code,
    input  logic [2:0]            inv_op,
    input  logic [9:0]            inv_asid,
    input  logic [18:0]           inv_va,
    input  logic [9:0]            csr_asid,
    input  logic [18:0]           csr_vppn,
    input  logic [TLBNUMSIZE-1:0] csr_idx,
    input  logic [5:0]            csr_ps,
    input  logic                  csr_ne,
    input  PhytranItem            csr_elo0,
    input  PhytranItem            csr_elo1,
    input  logic                  csr_g,
    input  logic [5:0]            csr_ecode,
    output logic                  srch_req,
    output logic [18:0]           s1_vppn,
    output logic [9:0]            s1_asid,
    output logic                  s1_odd,
    input  logic [TLBNUMSIZE-1:0] s1_index,
    input  logic                  s1_ne,
    output logic [TLBNUMSIZE-1:0] r_index,
    input  logic [5:0]            r_ps,
    input  logic [9:0]            r_asid,
    input  logic                  r_ne,
    input  logic                  r_g,
    input  logic [18:0]           r_vppn,
    input  PhytranItem            r_phytran0,
    input  PhytranItem            r_phytran1,
    output logic                  we,
    output logic [TLBNUMSIZE-1:0] w_index,
    output logic [5:0]            w_ps,
    output logic                  w_ne,
    output logic [9:0]            w_asid,
    output logic [18:0]           w_vppn,
    output logic                  w_g,
    output PhytranItem            w_phytran0,
    output PhytranItem            w_phytran1,
    output logic                  fe,
    output logic [2:0]            f_op,
    output logic [9:0]            f_asid,
    output logic [18:0]           f_va,
    output logic                  done,
    output logic                  srch_we,
    output logic [TLBNUMSIZE-1:0] srch_index,
    output logic                  srch_ne,
    output logic                  rd_we,
    output logic [5:0]            rd_ps,
    output logic                  rd_ne,
    output logic [9:0]            rd_asid,
    output logic [18:0]           rd_vppn,
    output logic                  rd_g,
    output PhytranItem            rd_phytran0,
    output PhytranItem            rd_phytran1,
    output logic                  op_ine
);

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;
    localparam logic [TLBNUMSIZE-1:0] FILL_LAST = TLBNUMSIZE'(TLBNUM - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t                state_q;
    logic [2:0]            op_q;
    logic                  inv_bad_q;
    logic [TLBNUMSIZE-1:0] fill_ptr_q;

    logic                  srch_req_q, we_q, w_ne_q, w_g_q, fe_q, done_q;
    logic [18:0]           s1_vppn_q, w_vppn_q, f_va_q, rd_vppn_q;
    logic [9:0]            s1_asid_q, w_asid_q, f_asid_q, rd_asid_q;
    logic [TLBNUMSIZE-1:0] r_index_q, w_index_q, srch_index_q;
    logic [5:0]            w_ps_q, rd_ps_q;
    logic [2:0]            f_op_q;
    PhytranItem            w_p0_q, w_p1_q, rd_p0_q, rd_p1_q;
    logic                  srch_we_q, srch_ne_q, rd_we_q, rd_ne_q, rd_g_q, op_ine_q;

    // Port outputs are loaded at the accept edge from the live CSR inputs, which is
    // the latch point; everything else clears each cycle so outputs are one-cycle pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            inv_bad_q    <= 1'b0;
            fill_ptr_q   <= '0;
            srch_req_q   <= 1'b0;
            s1_vppn_q    <= '0;
            s1_asid_q    <= '0;
            r_index_q    <= '0;
            we_q         <= 1'b0;
            w_index_q    <= '0;
            w_ps_q       <= '0;
            w_ne_q       <= 1'b0;
            w_asid_q     <= '0;
            w_vppn_q     <= '0;
            w_g_q        <= 1'b0;
            w_p0_q       <= '0;
            w_p1_q       <= '0;
            fe_q         <= 1'b0;
            f_op_q       <= '0;
            f_asid_q     <= '0;
            f_va_q       <= '0;
            done_q       <= 1'b0;
            srch_we_q    <= 1'b0;
            srch_index_q <= '0;
            srch_ne_q    <= 1'b0;
            rd_we_q      <= 1'b0;
            rd_ps_q      <= '0;
            rd_ne_q      <= 1'b0;
            rd_asid_q    <= '0;
            rd_vppn_q    <= '0;
            rd_g_q       <= 1'b0;
            rd_p0_q      <= '0;
            rd_p1_q      <= '0;
            op_ine_q     <= 1'b0;
        end else begin
            srch_req_q   <= 1'b0;
            s1_vppn_q    <= '0;
            s1_asid_q    <= '0;
            r_index_q    <= '0;
            we_q         <= 1'b0;
            w_index_q    <= '0;
            w_ps_q       <= '0;
            w_ne_q       <= 1'b0;
            w_asid_q     <= '0;
            w_vppn_q     <= '0;
            w_g_q        <= 1'b0;
            w_p0_q       <= '0;
            w_p1_q       <= '0;
            fe_q         <= 1'b0;
            f_op_q       <= '0;
            f_asid_q     <= '0;
            f_va_q       <= '0;
            done_q       <= 1'b0;
            srch_we_q    <= 1'b0;
            srch_index_q <= '0;
            srch_ne_q    <= 1'b0;
            rd_we_q      <= 1'b0;
            rd_ps_q      <= '0;
            rd_ne_q      <= 1'b0;
            rd_asid_q    <= '0;
            rd_vppn_q    <= '0;
            rd_g_q       <= 1'b0;
            rd_p0_q      <= '0;
            rd_p1_q      <= '0;
            op_ine_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (op_valid) begin
                        state_q   <= S_EXEC;
                        op_q      <= op_code;
                        inv_bad_q <= (inv_op > 3'd6);
                        case (op_code)
                            OP_SRCH: begin
                                srch_req_q <= 1'b1;
                                s1_vppn_q  <= csr_vppn;
                                s1_asid_q  <= csr_asid;
                            end
                            OP_RD: r_index_q <= csr_idx;
                            OP_WR, OP_FILL: begin
                                we_q      <= 1'b1;
                                w_index_q <= (op_code == OP_WR) ? csr_idx : fill_ptr_q;
                                w_ps_q    <= csr_ps;
                                // A refill handler always installs a valid entry.
                                w_ne_q    <= (csr_ecode == 6'h3f) ? 1'b0 : csr_ne;
                                w_asid_q  <= csr_asid;
                                w_vppn_q  <= csr_vppn;
                                w_g_q     <= csr_g;
                                w_p0_q    <= csr_elo0;
                                w_p1_q    <= csr_elo1;
                            end
                            OP_INV: begin
                                if (inv_op <= 3'd6) begin
                                    fe_q     <= 1'b1;
                                    f_op_q   <= inv_op;
                                    f_asid_q <= inv_asid;
                                    f_va_q   <= inv_va;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_EXEC: begin
                    state_q <= S_RESP;
                    done_q  <= 1'b1;
                    case (op_q)
                        OP_SRCH: begin
                            srch_we_q    <= 1'b1;
                            srch_ne_q    <= s1_ne;
                            srch_index_q <= s1_ne ? '0 : s1_index;
                        end
                        OP_RD: begin
                            rd_we_q <= 1'b1;
                            rd_ne_q <= r_ne;
                            if (!r_ne) begin
                                rd_ps_q   <= r_ps;
                                rd_asid_q <= r_asid;
                                rd_vppn_q <= r_vppn;
                                rd_g_q    <= r_g;
                                rd_p0_q   <= r_phytran0;
                                rd_p1_q   <= r_phytran1;
                            end
                        end
                        OP_WR: ;
                        OP_FILL: fill_ptr_q <= (fill_ptr_q == FILL_LAST) ? '0 : fill_ptr_q + 1'b1;
                        OP_INV: op_ine_q <= inv_bad_q;
                        default: op_ine_q <= 1'b1;
                    endcase
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign op_ready    = (state_q == S_IDLE);
    assign srch_req    = srch_req_q;
    assign s1_vppn     = s1_vppn_q;
    assign s1_asid     = s1_asid_q;
    assign s1_odd      = 1'b0;
    assign r_index     = r_index_q;
    assign we          = we_q;
    assign w_index     = w_index_q;
    assign w_ps        = w_ps_q;
    assign w_ne        = w_ne_q;
    assign w_asid      = w_asid_q;
    assign w_vppn      = w_vppn_q;
    assign w_g         = w_g_q;
    assign w_phytran0  = w_p0_q;
    assign w_phytran1  = w_p1_q;
    assign fe          = fe_q;
    assign f_op        = f_op_q;
    assign f_asid      = f_asid_q;
    assign f_va        = f_va_q;
    assign done        = done_q;
    assign srch_we     = srch_we_q;
    assign srch_index  = srch_index_q;
    assign srch_ne     = srch_ne_q;
    assign rd_we       = rd_we_q;
    assign rd_ps       = rd_ps_q;
    assign rd_ne       = rd_ne_q;
    assign rd_asid     = rd_asid_q;
    assign rd_vppn     = rd_vppn_q;
    assign rd_g        = rd_g_q;
    assign rd_phytran0 = rd_p0_q;
    assign rd_phytran1 = rd_p1_q;
    assign op_ine      = op_ine_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: a behavioural TLB array answers the search/read ports and an op-level model predicts every output.
module tb_tlb_op_ctrl;
    import csr_tlbDefines::*;

    localparam int N = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        op_valid, op_ready, csr_ne, csr_g, s1_odd, s1_ne, r_ne, r_g, srch_req;
    logic [2:0]  op_code, inv_op, f_op;
    logic [9:0]  inv_asid, csr_asid, s1_asid, r_asid, w_asid, f_asid, rd_asid;
    logic [18:0] inv_va, csr_vppn, s1_vppn, r_vppn, w_vppn, f_va, rd_vppn;
    logic [3:0]  csr_idx, s1_index, r_index, w_index, srch_index;
    logic [5:0]  csr_ps, csr_ecode, r_ps, w_ps, rd_ps;
    PhytranItem  csr_elo0, csr_elo1, r_phytran0, r_phytran1, w_phytran0, w_phytran1, rd_phytran0, rd_phytran1;
    logic        we, w_ne, w_g, fe, done, srch_we, srch_ne, rd_we, rd_ne, rd_g, op_ine;

    tlb_op_ctrl #(.TLBNUM(16), .TLBNUMSIZE(4)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va), .csr_asid(csr_asid), .csr_vppn(csr_vppn),
        .csr_idx(csr_idx), .csr_ps(csr_ps), .csr_ne(csr_ne), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1),
        .csr_g(csr_g), .csr_ecode(csr_ecode), .srch_req(srch_req), .s1_vppn(s1_vppn), .s1_asid(s1_asid),
        .s1_odd(s1_odd), .s1_index(s1_index), .s1_ne(s1_ne), .r_index(r_index), .r_ps(r_ps),
        .r_asid(r_asid), .r_ne(r_ne), .r_g(r_g), .r_vppn(r_vppn), .r_phytran0(r_phytran0),
        .r_phytran1(r_phytran1), .we(we), .w_index(w_index), .w_ps(w_ps), .w_ne(w_ne), .w_asid(w_asid),
        .w_vppn(w_vppn), .w_g(w_g), .w_phytran0(w_phytran0), .w_phytran1(w_phytran1), .fe(fe),
        .f_op(f_op), .f_asid(f_asid), .f_va(f_va), .done(done), .srch_we(srch_we),
        .srch_index(srch_index), .srch_ne(srch_ne), .rd_we(rd_we), .rd_ps(rd_ps), .rd_ne(rd_ne),
        .rd_asid(rd_asid), .rd_vppn(rd_vppn), .rd_g(rd_g), .rd_phytran0(rd_phytran0),
        .rd_phytran1(rd_phytran1), .op_ine(op_ine)
    );

    typedef struct packed {
        logic op_ready; logic srch_req; logic [18:0] s1_vppn; logic [9:0] s1_asid; logic s1_odd;
        logic [3:0] r_index; logic we; logic [3:0] w_index; logic [5:0] w_ps; logic w_ne;
        logic [9:0] w_asid; logic [18:0] w_vppn; logic w_g; PhytranItem w_p0; PhytranItem w_p1;
        logic fe; logic [2:0] f_op; logic [9:0] f_asid; logic [18:0] f_va; logic done;
        logic srch_we; logic [3:0] srch_index; logic srch_ne; logic rd_we; logic [5:0] rd_ps;
        logic rd_ne; logic [9:0] rd_asid; logic [18:0] rd_vppn; logic rd_g; PhytranItem rd_p0;
        PhytranItem rd_p1; logic op_ine;
    } outv_t;

    outv_t dv;
    assign dv = {op_ready, srch_req, s1_vppn, s1_asid, s1_odd, r_index, we, w_index, w_ps, w_ne,
                 w_asid, w_vppn, w_g, w_phytran0, w_phytran1, fe, f_op, f_asid, f_va, done,
                 srch_we, srch_index, srch_ne, rd_we, rd_ps, rd_ne, rd_asid, rd_vppn, rd_g,
                 rd_phytran0, rd_phytran1, op_ine};

    typedef struct {
        logic e; logic [5:0] ps; logic [9:0] asid; logic [18:0] vppn; logic g;
        PhytranItem p0; PhytranItem p1;
    } ent_t;

    typedef struct {
        logic [2:0] opc; logic [2:0] inv_op; logic [9:0] inv_asid; logic [18:0] inv_va;
        logic [9:0] asid; logic [18:0] vppn; logic [3:0] idx; logic [5:0] ps; logic ne;
        PhytranItem e0; PhytranItem e1; logic g; logic [5:0] ecode;
    } op_t;

    typedef struct { op_t op; logic [31:0] key; } vec_t;

    ent_t tlb [N];
    int   fptr;
    int   checks = 0;
    int   errors = 0;

    // The TLB array as seen from its search-1 and read ports.
    always_comb begin
        s1_ne    = 1'b1;
        s1_index = '0;
        for (int i = N - 1; i >= 0; i--)
            if (tlb[i].e && tlb[i].vppn == s1_vppn && (tlb[i].g || tlb[i].asid == s1_asid)) begin
                s1_ne    = 1'b0;
                s1_index = 4'(i);
            end
    end
    assign r_ne       = !tlb[r_index].e;
    assign r_ps       = tlb[r_index].ps;
    assign r_asid     = tlb[r_index].asid;
    assign r_vppn     = tlb[r_index].vppn;
    assign r_g        = tlb[r_index].g;
    assign r_phytran0 = tlb[r_index].p0;
    assign r_phytran1 = tlb[r_index].p1;

    task automatic chk(input string nm, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    function automatic logic [4:0] search(input logic [18:0] v, input logic [9:0] a);
        search = 5'h10;
        for (int i = N - 1; i >= 0; i--)
            if (tlb[i].e && tlb[i].vppn == v && (tlb[i].g || tlb[i].asid == a)) search = {1'b0, 4'(i)};
    endfunction

    task automatic predict(input op_t o, output outv_t ex, output outv_t rs);
        logic [4:0] s;
        ent_t en;
        ex = '0;
        rs = '0;
        rs.done = 1'b1;
        case (o.opc)
            3'd0: begin
                ex.srch_req = 1'b1; ex.s1_vppn = o.vppn; ex.s1_asid = o.asid;
                s = search(o.vppn, o.asid);
                rs.srch_we = 1'b1; rs.srch_ne = s[4]; rs.srch_index = s[3:0];
            end
            3'd1: begin
                ex.r_index = o.idx;
                en = tlb[o.idx];
                rs.rd_we = 1'b1; rs.rd_ne = !en.e;
                if (en.e) begin
                    rs.rd_ps = en.ps; rs.rd_asid = en.asid; rs.rd_vppn = en.vppn;
                    rs.rd_g = en.g; rs.rd_p0 = en.p0; rs.rd_p1 = en.p1;
                end
            end
            3'd2, 3'd3: begin
                ex.we = 1'b1;
                ex.w_index = (o.opc == 3'd2) ? o.idx : 4'(fptr);
                ex.w_ps = o.ps; ex.w_ne = (o.ecode == 6'h3f) ? 1'b0 : o.ne;
                ex.w_asid = o.asid; ex.w_vppn = o.vppn; ex.w_g = o.g; ex.w_p0 = o.e0; ex.w_p1 = o.e1;
            end
            3'd4: begin
                if (o.inv_op <= 3'd6) begin
                    ex.fe = 1'b1; ex.f_op = o.inv_op; ex.f_asid = o.inv_asid; ex.f_va = o.inv_va;
                end else rs.op_ine = 1'b1;
            end
            default: rs.op_ine = 1'b1;
        endcase
    endtask

    task automatic apply(input op_t o);
        logic [3:0] wi;
        logic kill, am, vm;
        if (o.opc == 3'd2 || o.opc == 3'd3) begin
            wi = (o.opc == 3'd2) ? o.idx : 4'(fptr);
            tlb[wi] = '{e: !((o.ecode == 6'h3f) ? 1'b0 : o.ne), ps: o.ps, asid: o.asid,
                        vppn: o.vppn, g: o.g, p0: o.e0, p1: o.e1};
            if (o.opc == 3'd3) fptr = (fptr + 1) % N;
        end else if (o.opc == 3'd4 && o.inv_op <= 3'd6) begin
            for (int i = 0; i < N; i++) begin
                am = (tlb[i].asid == o.inv_asid);
                vm = (tlb[i].vppn == o.inv_va);
                case (o.inv_op)
                    3'd2:    kill = tlb[i].g;
                    3'd3:    kill = !tlb[i].g;
                    3'd4:    kill = !tlb[i].g && am;
                    3'd5:    kill = !tlb[i].g && am && vm;
                    3'd6:    kill = (tlb[i].g || am) && vm;
                    default: kill = 1'b1;
                endcase
                if (kill) tlb[i].e = 1'b0;
            end
        end
    endtask

    task automatic drive(input op_t o);
        op_code = o.opc; inv_op = o.inv_op; inv_asid = o.inv_asid; inv_va = o.inv_va;
        csr_asid = o.asid; csr_vppn = o.vppn; csr_idx = o.idx; csr_ps = o.ps; csr_ne = o.ne;
        csr_elo0 = o.e0; csr_elo1 = o.e1; csr_g = o.g; csr_ecode = o.ecode;
    endtask

    function automatic logic [18:0] rvppn();
        case ($urandom_range(0, 3))
            0:       rvppn = 19'h12345;
            1:       rvppn = 19'h00abc;
            2:       rvppn = 19'h7ffff;
            default: rvppn = 19'($urandom);
        endcase
    endfunction

    function automatic op_t rand_op();
        op_t o;
        case ($urandom_range(0, 9))
            0, 1:    o.opc = 3'd0;
            2, 9:    o.opc = 3'd1;
            3, 4:    o.opc = 3'd2;
            5, 6:    o.opc = 3'd3;
            7:       o.opc = 3'd4;
            default: o.opc = 3'($urandom_range(5, 7));
        endcase
        o.inv_op = 3'($urandom); o.inv_asid = 10'($urandom_range(0, 3)); o.inv_va = rvppn();
        o.asid = 10'($urandom_range(0, 3)); o.vppn = rvppn(); o.idx = 4'($urandom);
        o.ps = 6'($urandom); o.ne = ($urandom_range(0, 3) == 0); o.g = 1'($urandom);
        o.e0 = PhytranItem'(26'($urandom)); o.e1 = PhytranItem'(26'($urandom));
        o.ecode = ($urandom_range(0, 1) == 0) ? 6'h3f : 6'($urandom);
        return o;
    endfunction

    function automatic op_t mk(input logic [2:0] opc, input logic [3:0] idx, input logic [18:0] vppn,
                               input logic [9:0] asid, input logic [2:0] iop);
        op_t o;
        o.opc = opc; o.idx = idx; o.vppn = vppn; o.asid = asid; o.inv_op = iop;
        o.inv_asid = asid; o.inv_va = vppn; o.ps = 6'd12; o.ne = 1'b0; o.g = 1'b0;
        o.e0 = PhytranItem'(26'h0123457); o.e1 = PhytranItem'(26'h2abcde5); o.ecode = 6'd0;
        return o;
    endfunction

    function automatic logic [31:0] key_of(input op_t o, input outv_t ex, input outv_t rs);
        case (o.opc)
            3'd0:       key_of = {27'd0, rs.srch_ne, rs.srch_index};
            3'd1:       key_of = {12'd0, rs.rd_ne, rs.rd_vppn};
            3'd2, 3'd3: key_of = {27'd0, ex.w_ne, ex.w_index};
            default:    key_of = {27'd0, rs.op_ine, ex.fe, ex.f_op};
        endcase
    endfunction

    task automatic scramble();
        op_code = 3'($urandom); inv_op = 3'($urandom); inv_asid = 10'($urandom); inv_va = 19'($urandom);
        csr_asid = 10'($urandom); csr_vppn = 19'($urandom); csr_idx = 4'($urandom);
        csr_ps = 6'($urandom); csr_ne = 1'($urandom); csr_g = 1'($urandom); csr_ecode = 6'($urandom);
        csr_elo0 = PhytranItem'(26'($urandom)); csr_elo1 = PhytranItem'(26'($urandom));
    endtask

    task automatic do_op(input op_t o, input bit nowait, output outv_t gex, output outv_t grs);
        outv_t idle, eex, ers;
        idle = '0;
        idle.op_ready = 1'b1;
        if (!nowait) @(negedge clk);
        chk("idle", dv, idle);
        predict(o, eex, ers);
        drive(o);
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        scramble();
        @(negedge clk);
        gex = dv;
        chk("exec", dv, eex);
        apply(o);
        @(negedge clk);
        grs = dv;
        chk("resp", dv, ers);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t  vt [9];
        outv_t gex, grs, idle;
        op_t   o;

        vt[0] = '{mk(3'd2, 4'd5, 19'h12345, 10'd3, 3'd0), 32'h05};
        vt[1] = '{mk(3'd1, 4'd5, 19'h0, 10'd0, 3'd0), 32'h12345};
        vt[2] = '{mk(3'd0, 4'd0, 19'h12345, 10'd3, 3'd0), 32'h05};
        vt[3] = '{mk(3'd0, 4'd0, 19'h12345, 10'd4, 3'd0), 32'h10};
        vt[4] = '{mk(3'd1, 4'd9, 19'h0, 10'd0, 3'd0), 32'h80000};
        vt[5] = '{mk(3'd4, 4'd0, 19'h12345, 10'd3, 3'd5), 32'h0d};
        vt[6] = '{mk(3'd0, 4'd0, 19'h12345, 10'd3, 3'd0), 32'h10};
        vt[7] = '{mk(3'd4, 4'd0, 19'h0, 10'd0, 3'd7), 32'h10};
        vt[8] = '{mk(3'd6, 4'd0, 19'h0, 10'd0, 3'd0), 32'h10};

        for (int i = 0; i < N; i++)
            tlb[i] = '{e: 1'b0, ps: 6'd0, asid: 10'd0, vppn: 19'd0, g: 1'b0, p0: '0, p1: '0};
        fptr = 0;
        idle = '0;
        idle.op_ready = 1'b1;
        reset = 1'b0;
        op_valid = 1'b0;
        drive(mk(3'd0, 4'd0, 19'h0, 10'd0, 3'd0));
        #12;
        chk("reset_state", dv, idle);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_op(vt[i].op, 1'b0, gex, grs);
            chk($sformatf("vec%0d_key", i), 320'(key_of(vt[i].op, gex, grs)), 320'(vt[i].key));
        end

        // Reset landing in EXEC of a WR must cut the write strobe asynchronously.
        o = mk(3'd2, 4'd9, 19'h55555, 10'd1, 3'd0);
        @(negedge clk);
        drive(o);
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(negedge clk);
        chk("rst_exec_we", 320'(we), 320'(1));
        #1 reset = 1'b0;
        #1 chk("rst_we_drop", 320'(we), 320'(0));
        chk("rst_outputs", dv, idle);
        fptr = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_no_done", 320'(done), 320'(0));
        reset = 1'b1;
        o = mk(3'd1, 4'd9, 19'h0, 10'd0, 3'd0);
        do_op(o, 1'b1, gex, grs);
        chk("rst_rd9_key", 320'(key_of(o, gex, grs)), 320'(32'h80000));

        for (int i = 0; i < 17; i++) begin
            o = mk(3'd3, 4'd0, 19'(19'h100 + i), 10'd2, 3'd0);
            o.ecode = 6'h3f;
            o.ne = 1'(i);
            do_op(o, 1'b0, gex, grs);
            chk($sformatf("fill%0d_key", i), 320'(key_of(o, gex, grs)), 320'(i % 16));
        end

        for (int i = 0; i < 300; i++) begin
            o = rand_op();
            do_op(o, 1'b0, gex, grs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Sequencer for the privileged TLB instructions TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB. It sits between the MEM/WB stage and the TLB array, and it is the initiator on the array's search-1, read, write and flush ports. It latches CSR operands when it accepts an op, drives exactly one TLB port for one cycle, and then returns CSR write-back data with a one-cycle done pulse. The pipeline holds younger instructions until that done pulse.

## Interface
Parameters:
- TLBNUM, 16, number of TLB entries
- TLBNUMSIZE, 4, index width (log2 TLBNUM)

Ports (PhytranItem is the package type from csr_tlbDefines):
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- op_valid / op_ready  in / out  1 / 1  op handshake; op_ready = (state==IDLE)
- op_code  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5–7 reserved
- inv_op, inv_asid, inv_va  in  3, 10, 19  INVTLB operands
- csr_asid, csr_vppn  in  10, 19  ASID.ASID, TLBEHI.VPPN
- csr_idx, csr_ps, csr_ne  in  TLBNUMSIZE, 6, 1  TLBIDX fields
- csr_elo0, csr_elo1  in  PhytranItem  TLBELO0/1 data
- csr_g  in  1  G bit (ELO0.G & ELO1.G)
- csr_ecode  in  6  ESTAT.Ecode; 0x3F = TLB refill
- srch_req  out  1  claims the search-1 port; MEM must not use it this cycle
- s1_vppn, s1_asid, s1_odd  out  19, 10, 1  search request; s1_odd = 0
- s1_index, s1_ne  in  TLBNUMSIZE, 1  search result (combinational)
- r_index  out  TLBNUMSIZE  read address
- r_ps, r_asid, r_ne, r_g, r_vppn, r_phytran0, r_phytran1  in  —  read data
- we, w_index, w_ps, w_ne, w_asid, w_vppn, w_g, w_phytran0, w_phytran1  out  —  write port
- fe, f_op, f_asid, f_va  out  1, 3, 10, 19  flush port
- done  out  1  one-cycle completion pulse
- srch_we, srch_index, srch_ne  out  1, TLBNUMSIZE, 1  TLBIDX update for SRCH
- rd_we, rd_ps, rd_ne, rd_asid, rd_vppn, rd_g, rd_phytran0, rd_phytran1  out  —  CSR update for RD
- op_ine  out  1  reserved op_code or inv_op > 6; valid with done

## Operation
- FSM states and transitions:
  - IDLE: if op_valid, latch op_code, inv_* and all csr_* inputs, then go to EXEC.
  - EXEC: always go to RESP.
  - RESP: always go to IDLE.
- EXEC drives exactly one TLB port, from the latched values only:
  - SRCH: srch_req=1; s1_vppn=csr_vppn, s1_asid=csr_asid. At the end of EXEC, register s1_index and s1_ne.
  - RD: r_index=csr_idx. At the end of EXEC, register all r_* inputs.
  - WR: we=1, w_index=csr_idx.
  - FILL: we=1, w_index=fill_ptr.
  - WR and FILL write fields: w_ps=csr_ps; w_asid=csr_asid; w_vppn=csr_vppn; w_g=csr_g; w_phytran0/1=csr_elo0/1.
  - WR and FILL w_ne: w_ne=0 when csr_ecode==0x3F; otherwise w_ne=csr_ne.
  - INV: if inv_op ≤ 6, fe=1 with f_op, f_asid and f_va from the latched inv_*. If inv_op > 6, fe stays 0.
  - Reserved op_code: no TLB port is driven.
- RESP: done=1 for every op.
  - SRCH: srch_we=1. A hit gives srch_ne=0 and srch_index=hit index. A miss gives srch_ne=1 and srch_index=0.
  - RD, entry valid: rd_we=1, rd_ne=0, all rd_* fields = captured r_* values.
  - RD, entry invalid (r_ne=1): rd_we=1, rd_ne=1, every other rd_* field 0.
  - INV with inv_op > 6, or reserved op_code: op_ine=1 and no CSR write.
- fill_ptr is a TLBNUMSIZE-bit counter.
  - It increments at the end of every FILL EXEC cycle and wraps from TLBNUM-1 to 0.
  - It is not affected by any other op.
- All outputs not named for the current state are 0.

## Timing
- Cycle A is the accept edge (op_valid & op_ready). The TLB port is active in cycle A+1, and done is high in cycle A+2. The next op can be accepted at the end of A+2, so the minimum spacing is 3 cycles per op.
- A TLB write or flush takes effect at the edge that ends EXEC. A search in the cycle after done sees the updated array.
- CSR inputs may change after accept; the latched copies are used.
- Asynchronous reset, at any time including mid-op:
  - state goes to IDLE, fill_ptr to 0, all outputs to 0, and op_ready to 1.
  - An in-flight op is dropped with no done.
  - If reset is asserted during EXEC, we and fe drop immediately.
- op_valid while busy is ignored; the requester holds it until op_ready.

## Test plan
- WR: csr_idx=5, vppn=0x12345, asid=0x3, csr_ne=0, ecode=0 → we=1 in A+1 with w_index=5 and w_ne=0. A following RD of index 5 returns rd_vppn=0x12345, rd_asid=3, rd_ne=0.
- SRCH: after the write above, set csr_vppn=0x12345, asid=3 → srch_we=1, srch_index=5, srch_ne=0. Repeat with asid=4 and G=0 → srch_ne=1.
- FILL: 17 FILLs from reset → w_index sequence 0,1,…,15,0. Any FILL with ecode=0x3F and csr_ne=1 → w_ne=0.
- RD of an invalid entry 9 → rd_we=1, rd_ne=1, rd_vppn=0, rd_asid=0, rd_ps=0.
- INV: inv_op=5, asid=3, va=0x12345 → fe=1 with f_op=5 for one cycle, and a later SRCH misses. inv_op=7 → fe=0, op_ine=1 with done.
- Reset asserted in EXEC of a WR → we falls immediately, no done, array unchanged. A new op is accepted in the first cycle after release.
